// File: rtl/player_ctrl.sv
// Player column front end: synchronises, debounces and edge-detects the three
// buttons, adds hold-to-repeat, and keeps a saturating column position.
module player_ctrl #(
  parameter int DB_CYCLES    = 4,
  parameter int REPEAT_DELAY = 8,
  parameter int REPEAT_RATE  = 4,
  parameter int MAX_POS      = 15,
  parameter int START_POS    = 3
) (
  input  logic       gameclk,
  input  logic       clr,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_center,
  output logic [3:0] plrpos,
  output logic       moved,
  output logic       dir
);

  localparam int CMAX_A = (DB_CYCLES > REPEAT_DELAY) ? DB_CYCLES : REPEAT_DELAY;
  localparam int CMAX   = (CMAX_A > REPEAT_RATE) ? CMAX_A : REPEAT_RATE;
  localparam int CNT_W  = (CMAX > 2) ? $clog2(CMAX) : 1;

  localparam logic [CNT_W-1:0] DB_LAST   = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DLY_LOAD  = CNT_W'(REPEAT_DELAY - 1);
  localparam logic [CNT_W-1:0] RATE_LOAD = CNT_W'(REPEAT_RATE - 1);
  localparam logic [3:0]       POS_MAX   = 4'(MAX_POS);
  localparam logic [3:0]       POS_START = 4'(START_POS);

  // Button index: 0 = left, 1 = right, 2 = centre.
  typedef enum logic [1:0] {ST_IDLE, ST_DELAY, ST_REPEAT} rpt_state_e;

  logic [2:0]       raw;
  logic [2:0]       s1_q, s1_d, s2_q, s2_d;
  logic [2:0]       db_q, db_d, db_prev_q, db_prev_d;
  logic [CNT_W-1:0] db_cnt_q [3];
  logic [CNT_W-1:0] db_cnt_d [3];
  rpt_state_e       st_q [2];
  rpt_state_e       st_d [2];
  logic [CNT_W-1:0] rpt_cnt_q [2];
  logic [CNT_W-1:0] rpt_cnt_d [2];
  logic             blk_q, blk_d;
  logic [3:0]       pos_q, pos_d;
  logic             moved_q, moved_d;
  logic             dir_q, dir_d;

  logic [2:0] press;
  logic [1:0] req;
  logic       both_held;
  logic       ctr_press;

  assign raw = {btn_center, btn_right, btn_left};

  // Synchroniser and debounce
  always_comb begin
    s1_d      = raw;
    s2_d      = s1_q;
    db_d      = db_q;
    db_prev_d = db_q;
    for (int i = 0; i < 3; i++) begin
      db_cnt_d[i] = db_cnt_q[i];
      if (s2_q[i] == db_q[i]) begin
        db_cnt_d[i] = '0;
      end else if (db_cnt_q[i] == DB_LAST) begin
        db_d[i]     = s2_q[i];
        db_cnt_d[i] = '0;
      end else begin
        db_cnt_d[i] = db_cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign press     = db_q & ~db_prev_q;
  assign both_held = db_q[0] & db_q[1];
  assign ctr_press = press[2];

  // Repeat FSMs; blk_q lets a button that outlived a two-button hold start
  // again without waiting for a fresh debounced edge.
  always_comb begin
    blk_d = both_held;
    for (int d = 0; d < 2; d++) begin
      req[d]       = 1'b0;
      st_d[d]      = st_q[d];
      rpt_cnt_d[d] = rpt_cnt_q[d];
      if (!db_q[d] || ctr_press || both_held) begin
        st_d[d] = ST_IDLE;
      end else begin
        case (st_q[d])
          ST_IDLE: begin
            if (press[d] || blk_q) begin
              req[d]       = 1'b1;
              st_d[d]      = ST_DELAY;
              rpt_cnt_d[d] = DLY_LOAD;
            end
          end
          ST_DELAY: begin
            if (rpt_cnt_q[d] == '0) begin
              req[d]       = 1'b1;
              st_d[d]      = ST_REPEAT;
              rpt_cnt_d[d] = RATE_LOAD;
            end else begin
              rpt_cnt_d[d] = rpt_cnt_q[d] - CNT_W'(1);
            end
          end
          ST_REPEAT: begin
            if (rpt_cnt_q[d] == '0) begin
              req[d]       = 1'b1;
              rpt_cnt_d[d] = RATE_LOAD;
            end else begin
              rpt_cnt_d[d] = rpt_cnt_q[d] - CNT_W'(1);
            end
          end
          default: st_d[d] = ST_IDLE;
        endcase
      end
    end
  end

  // Position update; boundary requests are dropped while the FSM keeps timing
  always_comb begin
    pos_d   = pos_q;
    moved_d = 1'b0;
    dir_d   = dir_q;
    if (ctr_press) begin
      pos_d   = POS_START;
      moved_d = (pos_q != POS_START);
    end else if (both_held) begin
      moved_d = 1'b0;
    end else if (req[0] && (pos_q != 4'd0)) begin
      pos_d   = pos_q - 4'd1;
      dir_d   = 1'b0;
      moved_d = 1'b1;
    end else if (req[1] && (pos_q != POS_MAX)) begin
      pos_d   = pos_q + 4'd1;
      dir_d   = 1'b1;
      moved_d = 1'b1;
    end
  end

  always_ff @(posedge gameclk) begin
    if (!clr) begin
      s1_q      <= '0;
      s2_q      <= '0;
      db_q      <= '0;
      db_prev_q <= '0;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
      for (int d = 0; d < 2; d++) begin
        st_q[d]      <= ST_IDLE;
        rpt_cnt_q[d] <= '0;
      end
      blk_q   <= 1'b0;
      pos_q   <= POS_START;
      moved_q <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      db_q      <= db_d;
      db_prev_q <= db_prev_d;
      for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
      for (int d = 0; d < 2; d++) begin
        st_q[d]      <= st_d[d];
        rpt_cnt_q[d] <= rpt_cnt_d[d];
      end
      blk_q   <= blk_d;
      pos_q   <= pos_d;
      moved_q <= moved_d;
      dir_q   <= dir_d;
    end
  end

  assign plrpos = pos_q;
  assign moved  = moved_q;
  assign dir    = dir_q;

endmodule
